conv_engine: RTL

CONV_ENGINE -- requirements
Module: conv_engine

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_window_mac.sv | 44 ++++
 rtl/conv_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } conv_state_t;

    // Post-processing works on a wide signed value so any ACC_W/OWIDTH pair fits.
    localparam int WIDE_W = 64;

    function automatic int acc_w(input int dwidth);
        return 2 * dwidth + 5;
    endfunction

    function automatic logic signed [WIDE_W-1:0] relu(input logic signed [WIDE_W-1:0] v);
        if (v < 0) begin
            return '0;
        end
        return v;
    endfunction

    function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] v,
                                                          input int owidth);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (owidth - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (owidth - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// Nine signed multipliers and a combinational adder tree: one 3x3 window
// dotted with one filter's taps, plus bias, computed exactly in ACC_W bits.
module conv_window_mac #(
    parameter int DWIDTH = 8,
    parameter int ACC_W  = 21
) (
    input  logic [9*DWIDTH-1:0] i_win,
    input  logic [9*DWIDTH-1:0] i_wgt,
    input  logic [15:0]         i_bias,
    output logic [ACC_W-1:0]    o_sum
);

    localparam int PW = 2 * DWIDTH + 1;

    logic signed [PW-1:0]    w_prod [9];
    logic signed [ACC_W-1:0] w_term [10];
    logic signed [ACC_W-1:0] w_l1   [5];
    logic signed [ACC_W-1:0] w_l2   [3];
    logic signed [ACC_W-1:0] w_l3   [2];

    // Pixels are unsigned, so they get a zero MSB before the signed multiply.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = PW'($signed({1'b0, i_win[k*DWIDTH +: DWIDTH]}))
                      * PW'($signed(i_wgt[k*DWIDTH +: DWIDTH]));
            w_term[k] = ACC_W'(w_prod[k]);
        end
        w_term[9] = ACC_W'($signed(i_bias));
    end

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            w_l1[k] = w_term[2*k] + w_term[2*k+1];
        end
        w_l2[0] = w_l1[0] + w_l1[1];
        w_l2[1] = w_l1[2] + w_l1[3];
        w_l2[2] = w_l1[4];
        w_l3[0] = w_l2[0] + w_l2[1];
        w_l3[1] = w_l2[2];
    end

    assign o_sum = w_l3[0] + w_l3[1];

endmodule

// File: rtl/conv_engine.sv
// Frame-buffered 3x3 convolution: load a raster frame, then stream one
// ReLU/saturated result per valid 3x3 window for every filter.
module conv_engine import conv_pkg::*; #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int DWIDTH      = 8,
    parameter int NUM_FILTERS = 3,
    parameter int OWIDTH      = 17,
    parameter int RELU_EN     = 1,
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int AW = (NUM_FILTERS*(IMG_H-2)*(IMG_W-2) > 1)
                        ? $clog2(NUM_FILTERS*(IMG_H-2)*(IMG_W-2)) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DWIDTH-1:0] pix_data,
    input  logic              wgt_we,
    input  logic [FW-1:0]     wgt_filt,
    input  logic [3:0]        wgt_tap,
    input  logic [DWIDTH-1:0] wgt_data,
    input  logic              bias_we,
    input  logic [FW-1:0]     bias_filt,
    input  logic [15:0]       bias_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OWIDTH-1:0] res_data,
    output logic [AW-1:0]     res_addr,
    output logic              res_last,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int NRES  = NUM_FILTERS * OUT_H * OUT_W;
    localparam int PXW   = $clog2(NPIX);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int NWGT  = NUM_FILTERS * 9;
    localparam int WIW   = $clog2(NWGT);
    localparam int ACC_W = acc_w(DWIDTH);

    conv_state_t r_state;
    logic [PXW-1:0]    r_pix_cnt;
    logic [FW-1:0]     r_filt;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [AW-1:0]     r_addr_cnt;
    logic              r_issued_all;
    logic              r_res_valid;
    logic [OWIDTH-1:0] r_res_data;
    logic [AW-1:0]     r_res_addr;
    logic              r_res_last;

    logic [DWIDTH-1:0] r_frame [NPIX];
    logic [DWIDTH-1:0] r_wgt   [NWGT];
    logic [15:0]       r_bias  [NUM_FILTERS];

    logic                     w_pix_fire;
    logic                     w_wgt_wr;
    logic                     w_bias_wr;
    logic [WIW-1:0]           w_wgt_idx;
    logic                     w_issue;
    logic                     w_res_fire;
    logic [9*DWIDTH-1:0]      w_win;
    logic [9*DWIDTH-1:0]      w_wts;
    logic [15:0]              w_bias;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [WIDE_W-1:0] w_wide;
    logic signed [WIDE_W-1:0] w_post;
    logic signed [WIDE_W-1:0] w_sat;

    // Handshakes: a beat/result transfers on the rising edge where valid and
    // ready are both high; a presented result holds until it transfers.
    assign w_pix_fire = pix_valid && (r_state == LOAD);
    assign w_res_fire = r_res_valid && res_ready;
    assign w_issue    = (r_state == COMPUTE) && !r_issued_all && (!r_res_valid || res_ready);

    assign w_wgt_wr  = wgt_we && (r_state == LOAD) && (int'(wgt_filt) < NUM_FILTERS)
                     && (wgt_tap < 4'd9);
    assign w_bias_wr = bias_we && (r_state == LOAD) && (int'(bias_filt) < NUM_FILTERS);
    assign w_wgt_idx = WIW'(int'(wgt_filt) * 9 + int'(wgt_tap));

    always_comb begin
        w_win = '0;
        w_wts = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_win[(3*r+c)*DWIDTH +: DWIDTH] =
                    r_frame[PXW'((int'(r_row) + r) * IMG_W + int'(r_col) + c)];
                w_wts[(3*r+c)*DWIDTH +: DWIDTH] = r_wgt[WIW'(int'(r_filt) * 9 + 3*r + c)];
            end
        end
    end

    assign w_bias = r_bias[r_filt];

    conv_window_mac #(
        .DWIDTH (DWIDTH),
        .ACC_W  (ACC_W)
    ) u_mac (
        .i_win  (w_win),
        .i_wgt  (w_wts),
        .i_bias (w_bias),
        .o_sum  (w_sum)
    );

    assign w_wide = WIDE_W'(w_sum);
    assign w_post = (RELU_EN != 0) ? relu(w_wide) : w_wide;
    assign w_sat  = saturate(w_post, OWIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPIX; i++) begin
                r_frame[i] <= '0;
            end
            for (int i = 0; i < NWGT; i++) begin
                r_wgt[i] <= '0;
            end
            for (int i = 0; i < NUM_FILTERS; i++) begin
                r_bias[i] <= '0;
            end
        end else begin
            if (w_pix_fire) begin
                r_frame[r_pix_cnt] <= pix_data;
            end
            if (w_wgt_wr) begin
                r_wgt[w_wgt_idx] <= wgt_data;
            end
            if (w_bias_wr) begin
                r_bias[bias_filt] <= bias_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD;
            r_pix_cnt    <= '0;
            r_filt       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_addr_cnt   <= '0;
            r_issued_all <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_addr   <= '0;
            r_res_last   <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_pix_fire) begin
                        if (r_pix_cnt == PXW'(NPIX - 1)) begin
                            r_pix_cnt <= '0;
                            r_state   <= COMPUTE;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (w_res_fire && r_res_last) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_issue) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_sat[OWIDTH-1:0];
                        r_res_addr  <= r_addr_cnt;
                        r_res_last  <= (r_addr_cnt == AW'(NRES - 1));
                        r_addr_cnt  <= r_addr_cnt + 1'b1;
                        if (r_addr_cnt == AW'(NRES - 1)) begin
                            r_issued_all <= 1'b1;
                        end
                        // Column is innermost, then row, then filter.
                        if (r_col == CW'(OUT_W - 1)) begin
                            r_col <= '0;
                            if (r_row == RW'(OUT_H - 1)) begin
                                r_row <= '0;
                                if (r_filt == FW'(NUM_FILTERS - 1)) begin
                                    r_filt <= '0;
                                end else begin
                                    r_filt <= r_filt + 1'b1;
                                end
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else if (w_res_fire) begin
                        r_res_valid <= 1'b0;
                    end
                end
                DONE: begin
                    r_state      <= LOAD;
                    r_pix_cnt    <= '0;
                    r_filt       <= '0;
                    r_row        <= '0;
                    r_col        <= '0;
                    r_addr_cnt   <= '0;
                    r_issued_all <= 1'b0;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign pix_ready = (r_state == LOAD);
    assign busy      = (r_state != LOAD);
    assign dbg_state = r_state;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_addr  = r_res_addr;
    assign res_last  = r_res_last;

endmodule
